// File: rtl/bash_axil_master.sv
// bash_axil_master
// ----------------
// Turns single commands into AXI4-Lite read or write transactions. Only one
// transaction is in flight at a time. Each AXI response comes back on a
// valid/ready response channel. A watchdog counts the cycles spent waiting on
// the AXI slave. If the limit is reached, it raises a sticky timeout flag but
// lets the transaction carry on.
//
// Parameters
//   ADDRLEN      AXI address width
//   XLEN         data width (32 only)
//   TIMEOUT_CYC  watchdog limit in cycles
//
// Ports
//   m_axi_aclk, m_axi_aresetn    clock, synchronous active-low reset
//   cmd_*                        command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                        response out (valid/ready, rdata, resp, write)
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
//   timeout_o                    sticky watchdog flag, cleared only by reset
module bash_axil_master #(
  parameter int ADDRLEN     = 32,
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               m_axi_aclk,
  input  logic               m_axi_aresetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDRLEN-1:0] cmd_addr,
  input  logic [XLEN-1:0]    cmd_wdata,
  input  logic [3:0]         cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic               rsp_write,
  output logic [ADDRLEN-1:0] m_axi_awaddr,
  output logic [2:0]         m_axi_awprot,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [XLEN-1:0]    m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic [ADDRLEN-1:0] m_axi_araddr,
  output logic [2:0]         m_axi_arprot,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [XLEN-1:0]    m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic               timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  state_t state_q, state_d;

  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [ADDRLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;
  logic               rsp_write_q, rsp_write_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  // All handshake outputs are decoded from registered state only, so no VALID
  // ever depends combinationally on a READY. The AW and W channels have their
  // own done flags, so each one can drop its VALID independently.
  // cmd_ready is qualified by reset, which keeps it low while reset is held.
  assign cmd_ready     = (state_q == IDLE) && m_axi_aresetn;
  assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_rready  = (state_q == RD_DATA);
  assign rsp_valid     = (state_q == RSP);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign timeout_o     = timeout_q;

  // Next-state and capture logic. A B or R beat that arrives outside its
  // waiting state falls through the case untouched, so it is ignored.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          state_d = cmd_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts only while the FSM stays in the states that wait on the
  // slave. It clears whenever it leaves them, and it saturates instead of
  // wrapping. The flag is set on the same edge the count reaches the limit.
  always_comb begin
    busy_q    = (state_q == WR) || (state_q == WR_RESP) ||
                (state_q == RD_ADDR) || (state_q == RD_DATA);
    busy_d    = (state_d == WR) || (state_d == WR_RESP) ||
                (state_d == RD_ADDR) || (state_d == RD_DATA);
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (busy_q && busy_d) begin
      wdog_d = (wdog_q == CNT_MAX) ? wdog_q : wdog_q + CNT_W'(1);
      if (wdog_d == CNT_MAX) timeout_d = 1'b1;
    end
  end

  // State register. Reset drops any in-flight transaction without a response.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
